// File: rtl/iomem_arbiter_pkg.sv
// Shared types and constants for the two-master iomem arbiter.
package iomem_pkg;

  localparam int unsigned NumMasters = 2;
  localparam int unsigned StrbW      = 4;
  localparam int unsigned AddrW      = 32;
  localparam int unsigned DataW      = 32;

  localparam logic [DataW-1:0] ErrRdataDefault = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } state_e;

endpackage

// File: rtl/iomem_arbiter_if.sv
// picorv32-style iomem handshake bundle; master drives the request, slave the response.
interface iomem_arbiter_if;
  import iomem_pkg::*;

  logic             valid;
  logic             ready;
  logic [StrbW-1:0] wstrb;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic [DataW-1:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);

endinterface

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one iomem slave between two masters, one transaction at a time.
// Define IOMEM_ARBITER_TIMEOUT_EN to add a slave-response timeout with a sticky error flag.
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  parameter logic [DataW-1:0] ERR_RDATA      = ErrRdataDefault
) (
  input  logic                  clk,
  input  logic                  resetn,
  iomem_arbiter_if.slave        m0,
  iomem_arbiter_if.slave        m1,
  iomem_arbiter_if.master       s,
  output logic [NumMasters-1:0] grant,
  output logic                  timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..65535");
  end

  state_e           state_q;
  logic             last_q;  // index of the master that last completed
  logic             busy, sel1, req_valid, tmo, fin;
  logic [DataW-1:0] rsp;

  assign busy      = (state_q != StIdle);
  assign sel1      = (state_q == StBusy1);
  assign req_valid = busy && (sel1 ? m1.valid : m0.valid);
  assign grant     = {state_q == StBusy1, state_q == StBusy0};

  assign s.valid = req_valid && !tmo;

  always_comb begin
    s.wstrb = '0;
    s.addr  = '0;
    s.wdata = '0;
    unique case (state_q)
      StBusy0: begin
        s.wstrb = m0.wstrb;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
      end
      StBusy1: begin
        s.wstrb = m1.wstrb;
        s.addr  = m1.addr;
        s.wdata = m1.wdata;
      end
      default: ;
    endcase
  end

  // Ready comes only from the slave handshake or the timeout, never from a master's valid.
  assign fin      = (s.valid && s.ready) || tmo;
  assign rsp      = tmo ? ERR_RDATA : s.rdata;
  assign m0.ready = fin && !sel1;
  assign m1.ready = fin && sel1;
  assign m0.rdata = m0.ready ? rsp : '0;
  assign m1.rdata = m1.ready ? rsp : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0.valid && (!m1.valid || last_q)) begin
            state_q <= StBusy0;
          end else if (m1.valid) begin
            state_q <= StBusy1;
          end
        end
        StBusy0, StBusy1: begin
          if (!req_valid) begin
            state_q <= StIdle;
          end else if (fin) begin
            state_q <= StIdle;
            last_q  <= sel1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IOMEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic        err_q;

  assign tmo         = req_valid && (cnt_q == TimeoutLimit);
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy) begin
        cnt_q <= '0;
      end else if (!s.ready) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_iomem_arbiter;
  import iomem_pkg::*;

`ifdef IOMEM_ARBITER_TIMEOUT_EN
  localparam bit          TmoEn         = 1'b1;
  localparam int unsigned TimeoutCycles = 4;
`else
  localparam bit          TmoEn         = 1'b0;
  localparam int unsigned TimeoutCycles = 255;
`endif
  localparam logic [31:0] ErrData  = 32'hDEAD_BEEF;
  localparam int          SlowDone = TmoEn ? 5 : 6;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        mv [2];
  logic [3:0]  mw [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic        sr;
  logic [31:0] srd;
  logic [1:0]  grant;
  logic        timeout_err;

  iomem_arbiter_if m0_if ();
  iomem_arbiter_if m1_if ();
  iomem_arbiter_if s_if ();

  assign m0_if.valid = mv[0];
  assign m0_if.wstrb = mw[0];
  assign m0_if.addr  = ma[0];
  assign m0_if.wdata = md[0];
  assign m1_if.valid = mv[1];
  assign m1_if.wstrb = mw[1];
  assign m1_if.addr  = ma[1];
  assign m1_if.wdata = md[1];
  assign s_if.ready  = sr;
  assign s_if.rdata  = srd;

  iomem_arbiter #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: who owns the bus, who won last, how long the owner has waited.
  int   owner;      // 0 = nobody, 1 = master 0, 2 = master 1
  int   last_win;
  int   waited;
  bit   err_seen;
  bit   expired;
  bit   done_m [2];
  logic [1:0]  e_grant;
  logic        e_sv;
  logic [3:0]  e_sw;
  logic [31:0] e_sa, e_sd;
  logic        e_rdy [2];
  logic [31:0] e_rd [2];

  task automatic model_outputs();
    int m;
    e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    e_sv = 1'b0; e_sw = '0; e_sa = '0; e_sd = '0; expired = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rdy[i] = 1'b0;
      e_rd[i]  = '0;
    end
    if (owner != 0) begin
      m = owner - 1;
      expired = TmoEn && mv[m] && (waited == int'(TimeoutCycles));
      e_sv = mv[m] && !expired;
      e_sw = mw[m]; e_sa = ma[m]; e_sd = md[m];
      if (expired) begin
        e_rdy[m] = 1'b1;
        e_rd[m]  = ErrData;
      end else if (e_sv && sr) begin
        e_rdy[m] = 1'b1;
        e_rd[m]  = srd;
      end
    end
  endtask

  task automatic model_edge();
    int m;
    model_outputs();
    done_m[0] = e_rdy[0];
    done_m[1] = e_rdy[1];
    if (!resetn) begin
      owner = 0; last_win = 1; waited = 0; err_seen = 1'b0;
    end else if (owner == 0) begin
      if (mv[0] && mv[1]) owner = (last_win == 0) ? 2 : 1;
      else if (mv[0]) owner = 1;
      else if (mv[1]) owner = 2;
      waited = 0;
    end else begin
      m = owner - 1;
      if (!mv[m]) begin
        owner = 0;
      end else if (e_rdy[m]) begin
        owner = 0;
        last_win = m;
        if (expired) err_seen = 1'b1;
      end else if (!sr) begin
        waited++;
      end
    end
  endtask

  // Called at posedge+1; compares at the falling edge once inputs have settled.
  task automatic settle();
    #4;
    model_outputs();
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("s_valid", 32'(s_if.valid), 32'(e_sv));
    check_eq("s_wstrb", 32'(s_if.wstrb), 32'(e_sw));
    check_eq("s_addr", s_if.addr, e_sa);
    check_eq("s_wdata", s_if.wdata, e_sd);
    check_eq("m0_ready", 32'(m0_if.ready), 32'(e_rdy[0]));
    check_eq("m0_rdata", m0_if.rdata, e_rd[0]);
    check_eq("m1_ready", 32'(m1_if.ready), 32'(e_rdy[1]));
    check_eq("m1_rdata", m1_if.rdata, e_rd[1]);
    check_eq("timeout_err", 32'(timeout_err), 32'(err_seen));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mw[i] = '0; ma[i] = '0; md[i] = '0;
    end
    sr = 1'b0; srd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    advance();
    resetn = 1'b1;
  endtask

  logic [1:0] tie_seq [6];
  int         p_ready;

  initial begin
    owner = 0; last_win = 1; waited = 0; err_seen = 1'b0;
    clear_inputs();
    resetn = 1'b0;
    advance();
    settle();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_s_valid", 32'(s_if.valid), 32'h0);
    advance();
    resetn = 1'b1;

    // Single read
    mv[0] = 1'b1; ma[0] = 32'h0300_0000; mw[0] = 4'h0; sr = 1'b1; srd = 32'h1234_5678;
    settle();
    check_eq("rd_c0_s_valid", 32'(s_if.valid), 32'h0);
    advance();
    settle();
    check_eq("rd_c1_grant", 32'(grant), 32'h1);
    check_eq("rd_c1_s_addr", s_if.addr, 32'h0300_0000);
    check_eq("rd_c1_m0_ready", 32'(m0_if.ready), 32'h1);
    check_eq("rd_c1_m0_rdata", m0_if.rdata, 32'h1234_5678);
    advance();
    mv[0] = 1'b0;
    settle();
    check_eq("rd_c2_grant", 32'(grant), 32'h0);
    advance();

    // Simultaneous, continuously held requests alternate
    do_reset();
    tie_seq[0] = 2'b00; tie_seq[1] = 2'b01; tie_seq[2] = 2'b00;
    tie_seq[3] = 2'b10; tie_seq[4] = 2'b00; tie_seq[5] = 2'b01;
    mv[0] = 1'b1; ma[0] = 32'h0300_0010;
    mv[1] = 1'b1; ma[1] = 32'h0200_0004; mw[1] = 4'b0011; md[1] = 32'hAABB_CCDD;
    sr = 1'b1; srd = 32'h0BAD_F00D;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_eq("tie_grant", 32'(grant), 32'(tie_seq[i]));
      if (i == 3) begin
        check_eq("tie_s_wstrb", 32'(s_if.wstrb), 32'h3);
        check_eq("tie_s_wdata", s_if.wdata, 32'hAABB_CCDD);
      end
      advance();
    end

    // Slow slave on master 1
    do_reset();
    mv[1] = 1'b1; ma[1] = 32'h0300_0020; mw[1] = 4'hF; md[1] = 32'h0102_0304;
    srd = 32'hCAFE_0001;
    for (int i = 0; i <= 6; i++) begin
      sr = (i == 6);
      settle();
      check_eq("slow_m1_ready", 32'(m1_if.ready), 32'(i == SlowDone));
      check_eq("slow_m0_ready", 32'(m0_if.ready), 32'h0);
      check_eq("slow_m0_rdata", m0_if.rdata, 32'h0);
      advance();
    end

    // Reset during BUSY0, pending m1 granted once m0 is idle
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h0300_0030;
    settle();
    advance();
    settle();
    check_eq("rstmid_grant", 32'(grant), 32'h1);
    advance();
    resetn = 1'b0; mv[0] = 1'b0; mv[1] = 1'b1; ma[1] = 32'h0300_0040;
    settle();
    advance();
    resetn = 1'b1;
    settle();
    check_eq("rstmid_after_grant", 32'(grant), 32'h0);
    check_eq("rstmid_after_m0_ready", 32'(m0_if.ready), 32'h0);
    advance();
    sr = 1'b1; srd = 32'h7777_0000;
    settle();
    check_eq("rstmid_m1_grant", 32'(grant), 32'h2);
    advance();

`ifdef IOMEM_ARBITER_TIMEOUT_EN
    // Unresponsive slave times out, error sticks, next transaction is normal
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h0300_0050;
    for (int i = 0; i <= 5; i++) begin
      settle();
      check_eq("tmo_m0_ready", 32'(m0_if.ready), 32'(i == 5));
      if (i == 5) check_eq("tmo_m0_rdata", m0_if.rdata, ErrData);
      advance();
    end
    mv[0] = 1'b0; mv[1] = 1'b1; ma[1] = 32'h0300_0060; sr = 1'b1; srd = 32'h55AA_55AA;
    settle();
    check_eq("tmo_err_set", 32'(timeout_err), 32'h1);
    advance();
    settle();
    check_eq("tmo_m1_rdata", m1_if.rdata, 32'h55AA_55AA);
    advance();
    mv[1] = 1'b0;
    settle();
    check_eq("tmo_err_sticky", 32'(timeout_err), 32'h1);
    advance();
`endif

    // Withdrawal in BUSY0 leaves last winner untouched
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h0300_0070;
    settle();
    advance();
    mv[0] = 1'b0;
    settle();
    check_eq("wd_s_valid", 32'(s_if.valid), 32'h0);
    check_eq("wd_m0_ready", 32'(m0_if.ready), 32'h0);
    advance();
    settle();
    check_eq("wd_idle_grant", 32'(grant), 32'h0);
    mv[0] = 1'b1; mv[1] = 1'b1; sr = 1'b1;
    advance();
    settle();
    check_eq("wd_tie_grant", 32'(grant), 32'h1);
    advance();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      p_ready = (c < 2000) ? 60 : 15;
      resetn = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && done_m[i]) begin
          mv[i] = 1'b0;
        end else if (mv[i] && $urandom_range(0, 49) == 0) begin
          mv[i] = 1'b0;
        end
        if (!mv[i] && !done_m[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1'b1;
          mw[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          ma[i] = $urandom;
          md[i] = $urandom;
        end
      end
      sr  = ($urandom_range(0, 99) < p_ready);
      srd = $urandom;
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
